serial_cla_adder16: RTL and testbench

SERIAL_CLA_ADDER16 -- requirements
Module: serial_cla_adder16

---
 rtl/serial_cla_adder16_if.sv | 24 ++
 rtl/serial_cla_adder16.sv | 104 ++++++++++
 tb/tb_serial_cla_adder16.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_cla_adder16_if.sv
// Operand/result bundle for the slice-serial 16-bit adder.
// master drives the request side; slave is the adder.
interface serial_cla_adder16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        co;
  logic        ovf;

  modport master (
    output start, a, b, sub, ci,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, a, b, sub, ci,
    output busy, done, sum, co, ovf
  );
endinterface

// File: rtl/serial_cla_adder16.sv
// 16-bit add/sub, one 4-bit CLA slice per cycle; start->done latency 5 edges, result held until next op.
// No backpressure: start is only sampled in IDLE and is dropped (not queued) while RUN/DONE.
module serial_cla_adder16 (
  input  logic                 clk,
  input  logic                 rst,
  serial_cla_adder16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k;
  logic [15:0] op_a, op_b, res;
  logic        cy;
  logic [15:0] sum_q;
  logic        co_q, ovf_q;
  logic        busy, done;

  logic [3:0]  sa, sb, p, g, c, s;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (k == 2'd3) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    sa = op_a[3:0];
    sb = op_b[3:0];
    case (k)
      2'd1: begin sa = op_a[7:4];   sb = op_b[7:4];   end
      2'd2: begin sa = op_a[11:8];  sb = op_b[11:8];  end
      2'd3: begin sa = op_a[15:12]; sb = op_b[15:12]; end
      default: ;
    endcase
  end

  // Flattened lookahead: every carry is a two-level function of p, g and cy.
  assign p    = sa ^ sb;
  assign g    = sa & sb;
  assign c[0] = g[0] | (p[0] & cy);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cy);
  assign s    = p ^ {c[2:0], cy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= 2'd0;
      op_a  <= 16'h0000;
      op_b  <= 16'h0000;
      cy    <= 1'b0;
      res   <= 16'h0000;
      sum_q <= 16'h0000;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          op_a <= bus.a;
          op_b <= bus.sub ? ~bus.b : bus.b;
          cy   <= bus.sub ? 1'b1 : bus.ci;
          k    <= 2'd0;
        end
        RUN: begin
          res[{k, 2'b00} +: 4] <= s;
          cy <= c[3];
          k  <= k + 2'd1;
          if (k == 2'd3) begin
            sum_q <= {s, res[11:0]};
            co_q  <= c[3];
            ovf_q <= c[3] ^ c[2];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_cla_adder16.sv
// Randomized + directed bench for serial_cla_adder16 against an arithmetic reference model.
module tb_serial_cla_adder16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  serial_cla_adder16_if bus ();

  serial_cla_adder16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 17-bit arithmetic plus sign-rule overflow; returns {ovf, co, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic sub, input logic ci);
    logic [16:0] r;
    logic        v;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end
    return {v, r};
  endfunction

  // Model timeline: age = edges since acceptance, -1 when idle.
  int          age = -1;
  logic [15:0] m_sum = 16'h0000;
  logic        m_co = 1'b0, m_ovf = 1'b0;
  logic [15:0] pa, pb;
  logic        psub, pci;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = -1; m_sum = 16'h0000; m_co = 1'b0; m_ovf = 1'b0;
    end else if (age < 0) begin
      if (bus.start === 1'b1) begin
        age = 0; pa = bus.a; pb = bus.b; psub = bus.sub; pci = bus.ci;
      end
    end else begin
      age++;
      if (age == 4) {m_ovf, m_co, m_sum} = ref_op(pa, pb, psub, pci);
      else if (age == 5) age = -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, (age >= 0 && age <= 3)});
      chk("done", {31'd0, bus.done}, {31'd0, (age == 4)});
      chk("sum",  {16'd0, bus.sum},  {16'd0, m_sum});
      chk("co",   {31'd0, bus.co},   {31'd0, m_co});
      chk("ovf",  {31'd0, bus.ovf},  {31'd0, m_ovf});
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic ci, input logic [15:0] e_sum, input logic e_co,
                       input logic e_ovf);
    int nbusy = 0;
    bit seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = sub; bus.ci = ci;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.sub = 1'($urandom); bus.ci = 1'($urandom);
    if (bus.busy) nbusy++;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) seen = 1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", nbusy, 4);
    chk("lit_sum", {16'd0, bus.sum}, {16'd0, e_sum});
    chk("lit_co",  {31'd0, bus.co},  {31'd0, e_co});
    chk("lit_ovf", {31'd0, bus.ovf}, {31'd0, e_ovf});
  endtask

  initial begin
    int ndone;
    logic [15:0] corner [6];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'h0001; corner[5] = 16'h5555;
    bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.sub = 1'b0; bus.ci = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);

    // Abort in the second RUN cycle; outputs must clear immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.ci = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum",  {16'd0, bus.sum},  32'd0);
    chk("rst_co",   {31'd0, bus.co},   32'd0);
    chk("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random start traffic with operand changes every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      bus.b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      bus.sub = 1'($urandom);
      bus.ci  = 1'($urandom);
    end

    // start held high: acceptance only every 6 cycles.
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      bus.start = 1'b1;
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.sub = 1'($urandom); bus.ci = 1'($urandom);
    end
    bus.start = 1'b0;
    chk("held_start_done_count", ndone, 10);
    repeat (8) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
